// File: rtl/memo_dados_pkg.sv
// Shared definitions for the memo_dados data memory: access sizes, FSM states, byte-enable helper.
// CLEAR state only exists when MEMO_DADOS_CLEAR_EN is defined.
package memo_dados_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

`ifdef MEMO_DADOS_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/memo_dados_align.sv
// Lane alignment for memo_dados: load extract with sign/zero extension, store lane replication
// and byte-enable generation. Purely combinational.
module memo_dados_align
    import memo_dados_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_in,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  byte_en
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:   load_data = mem_word;
        endcase
    end

    // Replicating the data across lanes lets the byte enables alone pick the destination.
    always_comb begin
        case (size)
            SIZE_BYTE: store_data = {4{store_in[7:0]}};
            SIZE_HALF: store_data = {2{store_in[15:0]}};
            default:   store_data = store_in;
        endcase
    end

    assign byte_en = byte_enable(size, lane);

endmodule

// File: rtl/memo_dados_ws.sv
// Byte-addressed data memory with programmable wait states and a memReady/memDone handshake.
// Define MEMO_DADOS_CLEAR_EN to zero the whole array after every reset before accepting requests.
module memo_dados_ws
    import memo_dados_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEMORY_SIZE   = 128,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [31:0]              writeData,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic [1:0]               accessSize,
    input  logic                     memUnsigned,
    output logic                     memReady,
    output logic                     memDone,
    output logic                     memError,
    output logic [31:0]              readData
);

    localparam int         IDX_W     = $clog2(MEMORY_SIZE);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                   state_reg, state_next;
    logic [3:0]               cnt_reg, cnt_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [31:0]              wdata_reg;
    logic [1:0]               size_reg;
    logic                     unsigned_reg;
    logic                     write_reg;
    logic                     conflict_reg;
    logic                     done_reg;
    logic                     error_reg;
    logic [31:0]              rdata_reg;

    logic [31:0]              mem [MEMORY_SIZE];

    logic [IDX_W-1:0]         word_idx;
    logic [1:0]               lane;
    logic                     out_of_range;
    logic                     misaligned;
    logic                     fault;
    logic                     accept;
    logic [31:0]              load_data;
    logic [31:0]              store_data;
    logic [3:0]               byte_en;
    logic [IDX_W-1:0]         wr_idx;
    logic [31:0]              wr_data;
    logic [3:0]               wr_be;

    assign accept   = (state_reg == IDLE) && (memRead || memWrite);
    assign word_idx = addr_reg[IDX_W+1:2];
    assign lane     = addr_reg[1:0];

    always_comb begin
        out_of_range = (addr_reg >> (IDX_W + 2)) != '0;
        case (size_reg)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_reg[0];
            SIZE_WORD: misaligned = addr_reg[1:0] != 2'b00;
            default:   misaligned = 1'b1;
        endcase
        fault = conflict_reg || out_of_range || misaligned;
    end

    memo_dados_align u_align (
        .mem_word    (mem[word_idx]),
        .lane        (lane),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .store_in    (wdata_reg),
        .load_data   (load_data),
        .store_data  (store_data),
        .byte_en     (byte_en)
    );

`ifdef MEMO_DADOS_CLEAR_EN
    logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;

    always_comb begin
        if (state_reg == CLEAR) begin
            wr_idx  = clr_idx_reg;
            wr_data = 32'd0;
            wr_be   = 4'b1111;
        end else begin
            wr_idx  = word_idx;
            wr_data = store_data;
            wr_be   = (state_reg == RESP && write_reg && !fault) ? byte_en : 4'b0000;
        end
    end
`else
    always_comb begin
        wr_idx  = word_idx;
        wr_data = store_data;
        wr_be   = (state_reg == RESP && write_reg && !fault) ? byte_en : 4'b0000;
    end
`endif

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
`ifdef MEMO_DADOS_CLEAR_EN
        clr_idx_next = clr_idx_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (memRead || memWrite) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : RESP;
                    cnt_next   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) state_next = RESP;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            RESP: state_next = IDLE;
`ifdef MEMO_DADOS_CLEAR_EN
            CLEAR: begin
                clr_idx_next = clr_idx_reg + 1'b1;
                if (&clr_idx_reg) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
`ifdef MEMO_DADOS_CLEAR_EN
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
`else
            state_reg   <= IDLE;
`endif
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'd0;
            size_reg     <= SIZE_BYTE;
            unsigned_reg <= 1'b0;
            write_reg    <= 1'b0;
            conflict_reg <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            rdata_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
`ifdef MEMO_DADOS_CLEAR_EN
            clr_idx_reg <= clr_idx_next;
`endif
            if (accept) begin
                addr_reg     <= address;
                wdata_reg    <= writeData;
                size_reg     <= accessSize;
                unsigned_reg <= memUnsigned;
                write_reg    <= memWrite;
                conflict_reg <= memRead && memWrite;
            end
            // Completion flags land with readData so the consumer samples all three together.
            done_reg  <= (state_reg == RESP);
            error_reg <= (state_reg == RESP) && fault;
            if (state_reg == RESP && !write_reg && !fault) rdata_reg <= load_data;
        end
    end

    assign memReady = (state_reg == IDLE);
    assign memDone  = done_reg;
    assign memError = error_reg;
    assign readData = rdata_reg;

endmodule

// File: tb/tb_memo_dados_ws.sv
// Self-checking bench for memo_dados_ws: directed vector table on a zero-wait instance,
// hand-written wait/reset sequences on a three-wait instance, randomized ops against a byte-array model.
module tb_memo_dados_ws;

    logic        clock = 1'b0;
    logic        resetN;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [1:0]  accessSize;
    logic        memUnsigned;
    logic        rd0, wr0, rd3, wr3;
    logic        ready0, done0, err0, ready3, done3, err3;
    logic [31:0] rdata0, rdata3;

    always #5 clock = ~clock;

    memo_dados_ws #(.ADDRESS_WIDTH(32), .MEMORY_SIZE(128), .WAIT_STATES(0)) dut0 (
        .clock(clock), .resetN(resetN), .address(address), .writeData(writeData),
        .memRead(rd0), .memWrite(wr0), .accessSize(accessSize), .memUnsigned(memUnsigned),
        .memReady(ready0), .memDone(done0), .memError(err0), .readData(rdata0)
    );

    memo_dados_ws #(.ADDRESS_WIDTH(32), .MEMORY_SIZE(128), .WAIT_STATES(3)) dut3 (
        .clock(clock), .resetN(resetN), .address(address), .writeData(writeData),
        .memRead(rd3), .memWrite(wr3), .accessSize(accessSize), .memUnsigned(memUnsigned),
        .memReady(ready3), .memDone(done3), .memError(err3), .readData(rdata3)
    );

    int tests = 0;
    int fails = 0;

    // Reference: one byte array per instance plus the last successful load result.
    logic [7:0]  mm [2][512];
    logic [31:0] last_rd [2];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  sz;
        bit          un;
        logic [31:0] exp_rd;
        bit          exp_er;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic model_op(input int d, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] sz, input bit un,
                            output logic [31:0] exp_rd, output bit exp_er);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        exp_er = (rd && wr) || (sz == 2'b11) || ((a % n) != 0) || (a >= 32'd512);
        if (!exp_er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][int'(a) + i];
                if (!un && n < 4 && v[8*n-1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                last_rd[d] = v;
            end
        end
        exp_rd = last_rd[d];
    endtask

    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input bit un,
                          output logic [31:0] rdat, output bit er, output int lat);
        int guard = 0;
        @(negedge clock);
        while (((d == 0) ? ready0 : ready3) !== 1'b1 && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 40) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: memReady got 0, required 1");
        end
        address = a; writeData = wd; accessSize = sz; memUnsigned = un;
        if (d == 0) begin rd0 = rd; wr0 = wr; end
        else        begin rd3 = rd; wr3 = wr; end
        @(posedge clock); #1;
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (((d == 0) ? done0 : done3) !== 1'b1 && lat < 40);
        rdat = (d == 0) ? rdata0 : rdata3;
        er   = (d == 0) ? err0 : err3;
        $display("[TB] dut%0d rd=%0d wr=%0d a=%h wd=%h sz=%0d u=%0d -> data=%h err=%0d lat=%0d",
                 (d == 0) ? 0 : 3, rd, wr, a, wd, sz, un, rdat, er, lat);
    endtask

    task automatic run_op(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input bit un);
        logic [31:0] exp_rd, act_rd;
        bit exp_er, act_er;
        int lat;
        model_op(d, rd, wr, a, wd, sz, un, exp_rd, exp_er);
        access(d, rd, wr, a, wd, sz, un, act_rd, act_er, lat);
        chk("op_readData", act_rd, exp_rd);
        chk("op_memError", 32'(act_er), 32'(exp_er));
        chk("op_latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                                bit un, logic [31:0] exp_rd, bit exp_er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.sz = sz; v.un = un;
        v.exp_rd = exp_rd; v.exp_er = exp_er;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] act_rd, m_rd, a;
        bit act_er, m_er, rd, wr, extra;
        logic [1:0] sz;
        int lat, low, k, r;

        resetN = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        address = 32'd0; writeData = 32'd0; accessSize = 2'b00; memUnsigned = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        repeat (3) @(negedge clock);
        chk("reset_memReady", 32'(ready0), 32'd1);
        chk("reset_memDone", 32'(done0), 32'd0);
        chk("reset_memError", 32'(err0), 32'd0);
        chk("reset_readData", rdata0, 32'd0);
        resetN = 1'b1;

        // Give every word a defined value before any load.
        for (int w = 0; w < 128; w++) begin
            run_op(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0);
            run_op(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0);
        end

        vecs[0]  = mk(0, 1, 32'h000, 32'hCAFEF00D, 2'b10, 0, 32'h00000000, 0);
        vecs[1]  = mk(0, 1, 32'h200, 32'h11111111, 2'b10, 0, 32'h00000000, 1);
        vecs[2]  = mk(1, 0, 32'h000, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0);
        vecs[3]  = mk(0, 1, 32'h010, 32'hDEADBEEF, 2'b10, 0, 32'hCAFEF00D, 0);
        vecs[4]  = mk(1, 0, 32'h010, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
        vecs[5]  = mk(0, 1, 32'h011, 32'hAAAAAA7F, 2'b00, 0, 32'hDEADBEEF, 0);
        vecs[6]  = mk(1, 0, 32'h011, 32'h0,        2'b00, 0, 32'h0000007F, 0);
        vecs[7]  = mk(1, 0, 32'h011, 32'h0,        2'b00, 1, 32'h0000007F, 0);
        vecs[8]  = mk(1, 0, 32'h010, 32'h0,        2'b10, 0, 32'hDEAD7FEF, 0);
        vecs[9]  = mk(0, 1, 32'h012, 32'h55558001, 2'b01, 0, 32'hDEAD7FEF, 0);
        vecs[10] = mk(1, 0, 32'h012, 32'h0,        2'b01, 0, 32'hFFFF8001, 0);
        vecs[11] = mk(1, 0, 32'h012, 32'h0,        2'b01, 1, 32'h00008001, 0);
        vecs[12] = mk(1, 0, 32'h013, 32'h0,        2'b10, 0, 32'h00008001, 1);
        vecs[13] = mk(1, 0, 32'h011, 32'h0,        2'b01, 0, 32'h00008001, 1);
        vecs[14] = mk(1, 0, 32'h200, 32'h0,        2'b10, 0, 32'h00008001, 1);
        vecs[15] = mk(1, 0, 32'h010, 32'h0,        2'b11, 0, 32'h00008001, 1);
        vecs[16] = mk(0, 1, 32'h013, 32'h12345678, 2'b10, 0, 32'h00008001, 1);
        vecs[17] = mk(1, 1, 32'h010, 32'h00000000, 2'b10, 0, 32'h00008001, 1);
        vecs[18] = mk(1, 0, 32'h010, 32'h0,        2'b10, 0, 32'h80017FEF, 0);
        vecs[19] = mk(1, 0, 32'h013, 32'h0,        2'b00, 0, 32'hFFFFFF80, 0);
        vecs[20] = mk(1, 0, 32'h013, 32'h0,        2'b00, 1, 32'h00000080, 0);

        for (int i = 0; i < 21; i++) begin
            model_op(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].sz, vecs[i].un,
                     m_rd, m_er);
            access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].sz, vecs[i].un,
                   act_rd, act_er, lat);
            chk($sformatf("vec%0d_readData", i), act_rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_memError", i), 32'(act_er), 32'(vecs[i].exp_er));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Three wait states: latency, memReady low time, ignored request during WAIT.
        run_op(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        model_op(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, m_rd, m_er);
        @(negedge clock);
        address = 32'h20; accessSize = 2'b10; memUnsigned = 1'b0; rd3 = 1'b1;
        @(posedge clock); #1;
        rd3 = 1'b0;
        low = (ready3 === 1'b0) ? 1 : 0;
        k = 0;
        while (k < 40) begin
            @(posedge clock); #1;
            k++;
            if (k == 1) begin rd3 = 1'b1; address = 32'h24; end
            if (k == 2) rd3 = 1'b0;
            if (done3 === 1'b1) break;
            if (ready3 === 1'b0) low++;
        end
        $display("[TB] dut3 lw a=00000020 -> data=%h err=%0d lat=%0d ready_low=%0d", rdata3, err3, k, low);
        chk("ws3_latency", 32'(k), 32'd4);
        chk("ws3_ready_low", 32'(low), 32'd4);
        chk("ws3_readData", rdata3, m_rd);
        chk("ws3_memError", 32'(err3), 32'd0);
        @(posedge clock); #1;
        chk("ws3_done_pulse", 32'(done3), 32'd0);
        extra = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (done3 === 1'b1) extra = 1'b1;
        end
        chk("ws3_ignored_request", 32'(extra), 32'd0);

        // Reset during WAIT of a store aborts it.
        @(negedge clock);
        address = 32'h20; writeData = 32'hFFFFFFFF; accessSize = 2'b10; wr3 = 1'b1;
        @(posedge clock); #1;
        wr3 = 1'b0;
        @(negedge clock);
        resetN = 1'b0;
        #1;
        $display("[TB] dut3 reset during store wait");
        chk("abort_memReady", 32'(ready3), 32'd1);
        chk("abort_memDone", 32'(done3), 32'd0);
        chk("abort_memError", 32'(err3), 32'd0);
        chk("abort_readData", rdata3, 32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        run_op(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);

        for (int i = 0; i < 400; i++) begin
            a  = 32'($urandom_range(0, 511));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(9, 31));
            r  = int'($urandom_range(0, 15));
            rd = (r <= 8);
            wr = (r == 0) || (r >= 9);
            run_op(i % 2, rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
